// File: rtl/hive_thread_ctrl_ring.sv
// Thread-control ring for the barrel-threaded hive core: rotating thread IDs, per-thread
// clear/IRQ/halt arbitration pipelined to the last stage, and the rbus control register bank.
module hive_thread_ctrl_ring #(
  parameter int                     THREADS     = 8,
  parameter int                     STAGES      = 8,
  parameter int                     ALU_W       = 32,
  parameter int                     RBUS_ADDR_W = 8,
  parameter logic [RBUS_ADDR_W-1:0] REG_BASE    = 'h10
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   cla_i,
  input  logic [THREADS-1:0]     xsr_i,
  input  logic                   irt_i,
  output logic [$clog2(THREADS)-1:0] id_o,
  output logic [$clog2(THREADS)-1:0] id_last_o,
  output logic                   clt_o,
  output logic                   irq_o,
  output logic                   hlt_o,
  output logic [THREADS-1:0]     irq_er_o,
  input  logic [RBUS_ADDR_W-1:0] rbus_addr_i,
  input  logic                   rbus_wr_i,
  input  logic                   rbus_rd_i,
  input  logic [ALU_W-1:0]       rbus_wr_data_i,
  output logic [ALU_W-1:0]       rbus_rd_data_o
);

  localparam int ID_W = $clog2(THREADS);
  localparam int PIPE = STAGES - 1;

  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    id_pipe [PIPE];
  logic [2:0]         ev_pipe [PIPE];
  logic [THREADS-1:0] en_q, pend_q, isr_q, err_q, clr_q, halt_q;
  logic [ALU_W-1:0]   time_q, rd_data_q;

  logic [THREADS-1:0]     cur_mask, irt_mask, isr_live, xsr_pend, xsr_err;
  logic [THREADS-1:0]     clt_mask, irq_mask, w_t;
  logic                   launch_clt, launch_hlt, launch_irq;
  logic [RBUS_ADDR_W-1:0] off;
  logic                   sel;
  logic                   wr_en, wr_pend, wr_err, wr_clr, wr_halt;
  logic [ALU_W-1:0]       rd_val;
  logic                   unused_wdata;

  assign unused_wdata = ^rbus_wr_data_i;

  // An IRQ return on this cycle frees the thread, so a simultaneous request
  // pends instead of flagging an error.
  always_comb begin
    cur_mask   = THREADS'(1) << id_q;
    irt_mask   = irt_i ? cur_mask : '0;
    isr_live   = isr_q & ~irt_mask;
    xsr_pend   = xsr_i & ~isr_live;
    xsr_err    = xsr_i & isr_live;
    launch_clt = cla_i | (|(clr_q & cur_mask));
    launch_hlt = ~launch_clt & (|(halt_q & cur_mask));
    launch_irq = ~launch_clt & ~launch_hlt & (|(pend_q & en_q & ~isr_q & cur_mask));
    clt_mask   = launch_clt ? cur_mask : '0;
    irq_mask   = launch_irq ? cur_mask : '0;
  end

  always_comb begin
    off     = rbus_addr_i - REG_BASE;
    sel     = off < RBUS_ADDR_W'(7);
    w_t     = rbus_wr_data_i[THREADS-1:0];
    wr_en   = rbus_wr_i & sel & (off[2:0] == 3'd0);
    wr_pend = rbus_wr_i & sel & (off[2:0] == 3'd1);
    wr_err  = rbus_wr_i & sel & (off[2:0] == 3'd3);
    wr_clr  = rbus_wr_i & sel & (off[2:0] == 3'd4);
    wr_halt = rbus_wr_i & sel & (off[2:0] == 3'd5);
    rd_val  = '0;
    case (off[2:0])
      3'd0:    rd_val = ALU_W'(en_q);
      3'd1:    rd_val = ALU_W'(pend_q);
      3'd2:    rd_val = ALU_W'(isr_q);
      3'd3:    rd_val = ALU_W'(err_q);
      3'd4:    rd_val = ALU_W'(clr_q);
      3'd5:    rd_val = ALU_W'(halt_q);
      3'd6:    rd_val = time_q;
      default: rd_val = '0;
    endcase
  end

  // CLR resets to all ones so every thread gets one clear pass after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      id_q      <= '0;
      en_q      <= '0;
      pend_q    <= '0;
      isr_q     <= '0;
      err_q     <= '0;
      clr_q     <= '1;
      halt_q    <= '0;
      time_q    <= '0;
      rd_data_q <= '0;
    end else begin
      id_q      <= (id_q == ID_W'(THREADS - 1)) ? '0 : id_q + ID_W'(1);
      en_q      <= wr_en ? w_t : en_q;
      pend_q    <= (pend_q | xsr_pend | ({THREADS{wr_pend}} & w_t)) & ~(clt_mask | irq_mask);
      isr_q     <= (isr_live & ~clt_mask) | irq_mask;
      err_q     <= (err_q & ~({THREADS{wr_err}} & w_t)) | xsr_err;
      clr_q     <= ((clr_q | {THREADS{cla_i}}) & ~clt_mask) | ({THREADS{wr_clr}} & w_t);
      halt_q    <= wr_halt ? w_t : halt_q;
      time_q    <= time_q + ALU_W'(1);
      rd_data_q <= (rbus_rd_i & sel) ? rd_val : '0;
    end
  end

  // Event slots carry {clt, irq, hlt} alongside the thread ID they belong to.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < PIPE; i++) begin
        id_pipe[i] <= '0;
        ev_pipe[i] <= '0;
      end
    end else begin
      id_pipe[0] <= id_q;
      ev_pipe[0] <= {launch_clt, launch_irq, launch_hlt};
      for (int i = 1; i < PIPE; i++) begin
        id_pipe[i] <= id_pipe[i-1];
        ev_pipe[i] <= ev_pipe[i-1];
      end
    end
  end

  assign id_o           = id_q;
  assign id_last_o      = id_pipe[PIPE-1];
  assign clt_o          = ev_pipe[PIPE-1][2];
  assign irq_o          = ev_pipe[PIPE-1][1];
  assign hlt_o          = ev_pipe[PIPE-1][0];
  assign irq_er_o       = err_q;
  assign rbus_rd_data_o = rd_data_q;

endmodule

// File: tb/tb_hive_thread_ctrl_ring.sv
// Directed bench for hive_thread_ctrl_ring: an 8-thread/8-stage ring carries the scenarios,
// a 4-thread/6-stage ring covers the small-configuration wrap, reset clears and TIME.
module tb_hive_thread_ctrl_ring;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cla, irt;
  logic [7:0]  xsr;
  logic [2:0]  id, id_last;
  logic        clt, irq, hlt;
  logic [7:0]  irq_er;
  logic [7:0]  addr;
  logic        wr, rd;
  logic [31:0] wdata, rdata;

  logic        cla_b, irt_b;
  logic [3:0]  xsr_b;
  logic [1:0]  id_b, id_last_b;
  logic        clt_b, irq_b, hlt_b;
  logic [3:0]  irq_er_b;
  logic [7:0]  addr_b;
  logic        wr_b, rd_b;
  logic [31:0] wdata_b, rdata_b;

  int tests_run = 0;
  int tests_failed = 0;

  hive_thread_ctrl_ring #(.THREADS(8), .STAGES(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cla_i(cla), .xsr_i(xsr), .irt_i(irt),
    .id_o(id), .id_last_o(id_last), .clt_o(clt), .irq_o(irq), .hlt_o(hlt),
    .irq_er_o(irq_er), .rbus_addr_i(addr), .rbus_wr_i(wr), .rbus_rd_i(rd),
    .rbus_wr_data_i(wdata), .rbus_rd_data_o(rdata)
  );

  hive_thread_ctrl_ring #(.THREADS(4), .STAGES(6)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .cla_i(cla_b), .xsr_i(xsr_b), .irt_i(irt_b),
    .id_o(id_b), .id_last_o(id_last_b), .clt_o(clt_b), .irq_o(irq_b), .hlt_o(hlt_b),
    .irq_er_o(irq_er_b), .rbus_addr_i(addr_b), .rbus_wr_i(wr_b), .rbus_rd_i(rd_b),
    .rbus_wr_data_i(wdata_b), .rbus_rd_data_o(rdata_b)
  );

  localparam logic [7:0] A_EN = 8'h10, A_PEND = 8'h11, A_ISR = 8'h12, A_ERR = 8'h13;
  localparam logic [7:0] A_CLR = 8'h14, A_HALT = 8'h15, A_TIME = 8'h16;

  task automatic rbus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic rbus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    @(posedge clk);
    #1;
    d = rdata;
    rd = 1'b0;
  endtask

  task automatic wait_id(input logic [2:0] t);
    int n;
    n = 0;
    @(negedge clk);
    while (id !== t && n < 16) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (id !== t) begin
      tests_failed++;
      $display("[TB] FAIL wait_id: id_o=%0d never reached %0d", id, t);
    end
  endtask

  task automatic watch(input int n, output int clt_n, output int irq_n, output int hlt_n,
                       output logic [7:0] clt_ids, output logic [7:0] irq_ids);
    clt_n = 0; irq_n = 0; hlt_n = 0; clt_ids = '0; irq_ids = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (clt) begin clt_n++; clt_ids = clt_ids | (8'b1 << id_last); end
      if (irq) begin irq_n++; irq_ids = irq_ids | (8'b1 << id_last); end
      if (hlt) hlt_n++;
    end
  endtask

  task automatic test_reset();
    logic [2:0] e_id, e_last;
    logic [1:0] e_id_b, e_last_b;
    logic       e_clt, e_clt_b;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({id, id_last, clt, irq, hlt, irq_er, rdata} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %0h required 0", {id, id_last, clt, irq, hlt, irq_er, rdata});
    end
    tests_run++;
    if ({id_b, id_last_b, clt_b, irq_b, hlt_b, irq_er_b, rdata_b} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs_b: got %0h required 0", {id_b, id_last_b, clt_b, irq_b, hlt_b, irq_er_b, rdata_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      e_id     = 3'(k % 8);
      e_clt    = (k >= 7 && k <= 14);
      e_last   = 3'(k - 7);
      e_id_b   = 2'(k % 4);
      e_clt_b  = (k >= 5 && k <= 8);
      e_last_b = 2'(k - 5);
      tests_run++;
      if (id !== e_id || clt !== e_clt || irq !== 1'b0 || hlt !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_clear cycle %0d: id=%0d clt=%b irq=%b hlt=%b required id=%0d clt=%b", k, id, clt, irq, hlt, e_id, e_clt);
      end
      if (e_clt) begin
        tests_run++;
        if (id_last !== e_last) begin
          tests_failed++;
          $display("[TB] FAIL reset_clear_id cycle %0d: id_last=%0d required %0d", k, id_last, e_last);
        end
      end
      tests_run++;
      if (id_b !== e_id_b || clt_b !== e_clt_b || (e_clt_b && id_last_b !== e_last_b)) begin
        tests_failed++;
        $display("[TB] FAIL reset_clear_b cycle %0d: id=%0d clt=%b id_last=%0d required id=%0d clt=%b id_last=%0d", k, id_b, clt_b, id_last_b, e_id_b, e_clt_b, e_last_b);
      end
    end
  endtask

  task automatic test_time_b();
    logic [31:0] t0, t1;
    @(negedge clk);
    addr_b = A_TIME; rd_b = 1'b1;
    @(posedge clk); #1; t0 = rdata_b;
    @(posedge clk); #1; t1 = rdata_b;
    rd_b = 1'b0;
    tests_run++;
    if (t1 !== t0 + 32'd1 || t0 === 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL time_step: reads %0d then %0d, required consecutive nonzero", t0, t1);
    end
    @(posedge clk); #1;
    tests_run++;
    if (rdata_b !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL rd_idle: got %0h required 0", rdata_b);
    end
    @(negedge clk);
    addr_b = 8'h17; rd_b = 1'b1;
    @(posedge clk); #1;
    rd_b = 1'b0;
    tests_run++;
    if (rdata_b !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL rd_unmapped: got %0h required 0", rdata_b);
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    int cn, in_, hn;
    logic [7:0] cid, iid;
    rbus_write(A_EN, 32'hFFFF_FFFF);
    rbus_read(A_EN, d);
    tests_run++;
    if (d !== 32'h0000_00FF) begin
      tests_failed++;
      $display("[TB] FAIL en_upper_zero: got %0h required ff", d);
    end
    @(negedge clk); xsr = 8'h08;
    @(negedge clk); xsr = 8'h00;
    watch(24, cn, in_, hn, cid, iid);
    tests_run++;
    if (in_ !== 1 || iid !== 8'h08 || cn !== 0 || hn !== 0) begin
      tests_failed++;
      $display("[TB] FAIL irq_once: irq count %0d ids %0h clt %0d hlt %0d required 1 08 0 0", in_, iid, cn, hn);
    end
    rbus_read(A_ISR, d);
    tests_run++;
    if (d !== 32'h08) begin
      tests_failed++;
      $display("[TB] FAIL isr_set: got %0h required 08", d);
    end
  endtask

  task automatic test_err();
    logic [31:0] d;
    int cn, in_, hn;
    logic [7:0] cid, iid;
    @(negedge clk); xsr = 8'h08;
    @(negedge clk); xsr = 8'h00;
    rbus_read(A_ERR, d);
    tests_run++;
    if (d !== 32'h08 || irq_er !== 8'h08) begin
      tests_failed++;
      $display("[TB] FAIL err_set: ERR %0h irq_er %0h required 08 08", d, irq_er);
    end
    watch(20, cn, in_, hn, cid, iid);
    rbus_read(A_PEND, d);
    tests_run++;
    if (in_ !== 0 || d !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL err_no_irq: irq count %0d PEND %0h required 0 0", in_, d);
    end
    rbus_write(A_ERR, 32'h08);
    rbus_read(A_ERR, d);
    tests_run++;
    if (d !== 32'h0 || irq_er !== 8'h0) begin
      tests_failed++;
      $display("[TB] FAIL err_w1c: ERR %0h irq_er %0h required 0 0", d, irq_er);
    end
  endtask

  task automatic test_irt();
    logic [31:0] d;
    wait_id(3'd3);
    irt = 1'b1;
    @(negedge clk); irt = 1'b0;
    rbus_read(A_ISR, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL irt_clear: ISR %0h required 0", d);
    end
  endtask

  task automatic test_halt();
    logic [31:0] d;
    int bad, cn, in_, hn;
    logic [7:0] cid, iid;
    rbus_write(A_HALT, 32'h20);
    rbus_write(A_PEND, 32'h20);
    repeat (16) @(posedge clk);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (hlt !== (id_last == 3'd5) || irq !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL halt_slots: %0d bad cycles required 0", bad);
    end
    rbus_read(A_PEND, d);
    tests_run++;
    if (d !== 32'h20) begin
      tests_failed++;
      $display("[TB] FAIL halt_pend_held: PEND %0h required 20", d);
    end
    rbus_write(A_HALT, 32'h0);
    watch(24, cn, in_, hn, cid, iid);
    tests_run++;
    if (in_ !== 1 || iid !== 8'h20) begin
      tests_failed++;
      $display("[TB] FAIL unhalt_irq: irq count %0d ids %0h required 1 20", in_, iid);
    end
    rbus_read(A_ISR, d);
    tests_run++;
    if (d !== 32'h20) begin
      tests_failed++;
      $display("[TB] FAIL unhalt_isr: ISR %0h required 20", d);
    end
  endtask

  task automatic test_clr_vs_xsr();
    logic [31:0] d;
    int cn, in_, hn;
    logic [7:0] cid, iid;
    @(negedge clk);
    addr = A_CLR; wdata = 32'h02; wr = 1'b1; xsr = 8'h02;
    @(negedge clk);
    wr = 1'b0; xsr = 8'h00;
    watch(24, cn, in_, hn, cid, iid);
    tests_run++;
    if (cn !== 1 || cid !== 8'h02 || in_ !== 0) begin
      tests_failed++;
      $display("[TB] FAIL clr_beats_xsr: clt count %0d ids %0h irq %0d required 1 02 0", cn, cid, in_);
    end
    rbus_read(A_PEND, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL clr_pend: PEND %0h required 0", d);
    end
  endtask

  task automatic test_cla();
    logic [31:0] d;
    int cn, in_, hn;
    logic [7:0] cid, iid;
    wait_id(3'd5);
    irt = 1'b1;
    @(negedge clk); irt = 1'b0;
    rbus_write(A_PEND, 32'h0C);
    repeat (20) @(posedge clk);
    rbus_read(A_ISR, d);
    tests_run++;
    if (d !== 32'h0C) begin
      tests_failed++;
      $display("[TB] FAIL cla_setup_isr: ISR %0h required 0c", d);
    end
    @(negedge clk); cla = 1'b1;
    @(negedge clk); cla = 1'b0;
    watch(16, cn, in_, hn, cid, iid);
    tests_run++;
    if (cn !== 8 || cid !== 8'hFF || in_ !== 0) begin
      tests_failed++;
      $display("[TB] FAIL cla_all: clt count %0d ids %0h irq %0d required 8 ff 0", cn, cid, in_);
    end
    rbus_read(A_ISR, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL cla_isr: ISR %0h required 0", d);
    end
    rbus_read(A_CLR, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL cla_clr_done: CLR %0h required 0", d);
    end
  endtask

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cla = 1'b0; irt = 1'b0; xsr = '0;
    addr = '0; wr = 1'b0; rd = 1'b0; wdata = '0;
    cla_b = 1'b0; irt_b = 1'b0; xsr_b = '0;
    addr_b = '0; wr_b = 1'b0; rd_b = 1'b0; wdata_b = '0;
    test_reset();
    test_time_b();
    test_irq();
    test_err();
    test_irt();
    test_halt();
    test_clr_vs_xsr();
    test_cla();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
